mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch port, the data port and the shared
// single-port RAM port around mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding system: the requesters plus the RAM that answers reads.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Instruction-fetch port (read only)
    logic              FReq;
    logic [ADDR_W-1:0] FAddr;
    logic              FAck;
    logic [DATA_W-1:0] FData;

    // Data port (load / store)
    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic              DAck;
    logic [DATA_W-1:0] DRData;

    // Shared RAM port
    logic [ADDR_W-1:0] RamAddr;
    logic [DATA_W-1:0] RamWData;
    logic              RamWe;
    logic [DATA_W-1:0] RamRData;

    // Status
    logic              Busy;

    modport slave (
        input  FReq, FAddr,
        output FAck, FData,
        input  DReq, DWe, DAddr, DWData,
        output DAck, DRData,
        output RamAddr, RamWData, RamWe,
        input  RamRData,
        output Busy
    );

    modport master (
        output FReq, FAddr,
        input  FAck, FData,
        output DReq, DWe, DAddr, DWData,
        input  DAck, DRData,
        input  RamAddr, RamWData, RamWe,
        output RamRData,
        input  Busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between an instruction
// fetch port and a data load/store port.
// Every access takes exactly four cycles: IDLE (grant) -> ACCESS (address and
// write enable on the RAM) -> CAPTURE (read data registered) -> DONE (ack).
// Addresses, write data and the store flag are sampled only at grant time, so
// requesters may change or drop their inputs once granted.
// Tie-break: by default the data port always wins a tie. Defining the macro
// MEM_ARB_RR_EN switches ties to round-robin using a last-granted flag that
// resets to "fetch", so the first tie after reset still goes to data.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic          Clk,
    input logic          Rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    // Control decoded from the current state
    logic              grant;
    logic              capture;
    logic              f_ack;
    logic              d_ack;
    logic              busy;

    // Arbitration result for the current IDLE cycle
    logic              pick_data;

    // Transaction context latched at grant
    logic              win_data;
    logic              win_we;

    // Registered RAM drive and result registers
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] f_data;
    logic [DATA_W-1:0] dr_data;

`ifdef MEM_ARB_RR_EN
    // 1 when the most recent grant went to the data port
    logic              last_data;
`endif

    // Decide which requester would win if a grant happened this cycle
    always_comb begin
        pick_data = 1'b0;
        if (bus.DReq && bus.FReq) begin
`ifdef MEM_ARB_RR_EN
            pick_data = ~last_data;
`else
            pick_data = 1'b1;
`endif
        end else begin
            pick_data = bus.DReq;
        end
    end

    // State register; reset abandons any transaction in flight without an ack
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        capture    = 1'b0;
        f_ack      = 1'b0;
        d_ack      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.FReq || bus.DReq) begin
                    grant      = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                capture    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                f_ack      = ~win_data;
                d_ack      = win_data;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's request at grant; the write enable lives only in ACCESS
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            win_data  <= 1'b0;
            win_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else if (grant) begin
            win_data  <= pick_data;
            win_we    <= pick_data & bus.DWe;
            ram_addr  <= pick_data ? bus.DAddr : bus.FAddr;
            ram_wdata <= pick_data ? bus.DWData : '0;
            ram_we    <= pick_data & bus.DWe;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Register the RAM read data into the winner's result register; stores capture nothing
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            f_data  <= '0;
            dr_data <= '0;
        end else if (capture) begin
            if (!win_data) begin
                f_data <= bus.RamRData;
            end else if (!win_we) begin
                dr_data <= bus.RamRData;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was granted last so the next tie goes to the other port
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_data <= 1'b0;
        end else if (grant) begin
            last_data <= pick_data;
        end
    end
`endif

    assign bus.RamAddr  = ram_addr;
    assign bus.RamWData = ram_wdata;
    assign bus.RamWe    = ram_we;
    assign bus.FData    = f_data;
    assign bus.DRData   = dr_data;
    assign bus.FAck     = f_ack;
    assign bus.DAck     = d_ack;
    assign bus.Busy     = busy;

    // The two acks are mutually exclusive
    a_ack_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(f_ack && d_ack));

    // The RAM is only written during ACCESS
    a_we_in_access: assert property (@(posedge Clk) disable iff (!Rst_n)
        ram_we |-> (state == ACCESS));

    // A grant always leads to an ack three cycles later
    a_fixed_latency: assert property (@(posedge Clk) disable iff (!Rst_n)
        grant |-> ##3 (f_ack || d_ack));

endmodule
